cu_fsm: RTL and testbench
=========================

Name: cu_fsm

Overview:
- Multicycle sequencer for the Otter MCU core.
- Steps each instruction through fetch, execute, optional memory wait and load writeback, plus interrupt entry.
- Drives the write enables and memory strobes that the combinational decoder does not produce, and supplies int_taken to that decoder.
- Handshakes with instruction and data memory that may insert wait states, with a timeout, and keeps a retired-instruction count.

Parameters:
- TIMEOUT, default 255: max cycles to wait for imem_ack/dmem_ack before abort.
- INSTRET_W, default 32: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction bits [6:0], valid in EXEC.
- func  in  3  instruction bits [14:12], valid in EXEC.
- intr  in  1  external interrupt request, level.
- mie  in  1  CSR global interrupt enable.
- imem_ack  in  1  instruction read complete; IR latched by datapath on this cycle.
- dmem_ack  in  1  data read/write complete.
- pc_rst  out  1  datapath PC reset pulse.
- pc_write  out  1  PC update enable.
- reg_write  out  1  register file write enable.
- mem_rden1  out  1  instruction read request.
- mem_rden2  out  1  data read request.
- mem_we2  out  1  data write request.
- csr_we  out  1  CSR write enable.
- int_taken  out  1  interrupt entry; to decoder and CSR.
- mret_exec  out  1  mret executing; CSR restores mie.
- bus_err  out  1  one-cycle timeout pulse.
- instret  out  INSTRET_W  retired instruction count.

Behaviour:
- States: INIT, FETCH, EXEC, MEM_WAIT, WB, INTR.
- State, instret, wait counter and intr_q are registered.
- All other outputs are combinational from state, opcode, func and acks. Outputs are 0 unless listed below.
- Reset (async, any time including mid-access): state=INIT, instret=0, wait counter=0, intr_q=0. Outputs fall immediately and no strobe survives reset.
- INIT: pc_rst=1 for exactly one cycle, then FETCH.
- intr_q <= intr each cycle. An interrupt is accepted when intr_q & mie at instruction completion.
- Completion next-state: INTR if accepted, else FETCH.
- FETCH:
  - mem_rden1=1.
  - On imem_ack: go to EXEC.
  - Otherwise stay and increment the wait counter.
- EXEC, decoded by opcode:
  - 0110011 R, 0010011 I, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR: reg_write=1, pc_write=1, complete.
  - 1100011 branch: pc_write=1, complete.
  - 0000011 load: mem_rden2=1. dmem_ack same cycle -> WB, else -> MEM_WAIT.
  - 0100011 store: mem_we2=1. If dmem_ack same cycle: pc_write=1, complete. Else -> MEM_WAIT.
  - 1110011 with func=001 (csrrw): reg_write=1, csr_we=1, pc_write=1, complete.
  - 1110011 with func=000 (mret): mret_exec=1, pc_write=1, always -> FETCH (no interrupt check this cycle).
  - Any other opcode: pc_write=1 only (NOP), complete.
- MEM_WAIT:
  - Holds the same strobe as EXEC (mem_rden2 or mem_we2, chosen from the latched load/store flag).
  - Load: on dmem_ack -> WB.
  - Store: on dmem_ack, pc_write=1 and complete.
- WB: reg_write=1, pc_write=1, complete.
- INTR: int_taken=1, pc_write=1, -> FETCH. The interrupt does not increment instret.
- instret:
  - Increments by 1 on every cycle where pc_write=1 and state!=INTR (includes NOP/illegal and mret).
  - Wraps modulo 2^INSTRET_W.
- Wait counter:
  - Cleared on every state change.
  - Counts in FETCH and MEM_WAIT while ack=0.
  - When it reaches TIMEOUT with no ack: bus_err=1 for that cycle, strobes drop next cycle, -> FETCH with no pc_write and no reg_write. The instruction is retried and instret is unchanged.
  - An ack arriving on the TIMEOUT cycle wins: normal path, no bus_err.
- Strobes (mem_rden1, mem_rden2, mem_we2) are never asserted simultaneously.

Test Plan:
- Reset release, imem_ack tied high, R-type opcode 0110011: pc_rst 1 cycle; then FETCH/EXEC alternate; reg_write and pc_write high in every EXEC; instret=3 after 3 instructions.
- Load (0000011) with dmem_ack delayed 2 cycles: EXEC -> MEM_WAIT(2) -> WB; mem_rden2 high 3 cycles; reg_write only in WB; instret +1.
- Store (0100011) with same-cycle ack, then store with ack after 4 cycles: first completes in EXEC; second holds mem_we2 5 cycles; pc_write only on the ack cycle; reg_write never asserted.
- intr=1, mie=1 during an ADDI: after EXEC, one INTR cycle with int_taken=1 and pc_write=1; instret unchanged by INTR. Repeat with mie=0: no INTR state.
- TIMEOUT=4, imem_ack held 0: bus_err pulses exactly once, on the cycle the counter reaches 4; FETCH is re-entered with no pc_write.
- rst_n asserted mid-MEM_WAIT on a store: mem_we2 drops asynchronously; instret=0; one pc_rst pulse after release.

Source files
------------

// File: rtl/cu_fsm_if.sv
// ----------------------------------------------------------------------------
// cu_fsm_if -- memory handshake bundle between the Otter control unit and the
// instruction/data memories.
//
//   mem_rden1  instruction read request      (control unit -> memory)
//   mem_rden2  data read request             (control unit -> memory)
//   mem_we2    data write request            (control unit -> memory)
//   bus_err    one-cycle wait-timeout pulse  (control unit -> system)
//   imem_ack   instruction read complete     (memory -> control unit)
//   dmem_ack   data read/write complete      (memory -> control unit)
//
// master: the control unit.  slave: the memory side.
// ----------------------------------------------------------------------------
interface cu_fsm_if;
    logic mem_rden1;
    logic mem_rden2;
    logic mem_we2;
    logic bus_err;
    logic imem_ack;
    logic dmem_ack;

    modport master (
        output mem_rden1, mem_rden2, mem_we2, bus_err,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  mem_rden1, mem_rden2, mem_we2, bus_err,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/cu_fsm.sv
// ----------------------------------------------------------------------------
// cu_fsm -- multicycle sequencer for the Otter MCU core.
//
// Steps each instruction through FETCH, EXEC, an optional MEM_WAIT and a load
// writeback (WB), with interrupt entry (INTR) after a completed instruction.
// Memory accesses may be stretched by wait states; a wait that reaches
// TIMEOUT cycles without an ack raises bus_err and restarts at FETCH.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   opcode, func       instruction bits [6:0] and [14:12], valid in EXEC
//   intr, mie          external interrupt level, CSR global interrupt enable
//   bus                memory strobes, acks and bus_err (cu_fsm_if.master)
//   pc_rst             datapath PC reset pulse (one cycle after reset release)
//   pc_write           PC update enable
//   reg_write, csr_we  register file / CSR write enables
//   int_taken          interrupt entry, to decoder and CSR
//   mret_exec          mret executing, CSR restores mie
//   instret            retired-instruction count, wraps modulo 2^INSTRET_W
// ----------------------------------------------------------------------------
module cu_fsm #(
    parameter int TIMEOUT   = 255,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func,
    input  logic                 intr,
    input  logic                 mie,
    cu_fsm_if.master             bus,
    output logic                 pc_rst,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 csr_we,
    output logic                 int_taken,
    output logic                 mret_exec,
    output logic [INSTRET_W-1:0] instret
);
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F_MRET    = 3'b000;
    localparam logic [2:0] F_CSRRW   = 3'b001;

    typedef enum logic [2:0] {
        INIT,
        FETCH,
        EXEC,
        MEM_WAIT,
        WB,
        INTR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic              intr_q;
    logic              is_store;   // access kind latched in EXEC for MEM_WAIT
    logic              complete;   // instruction finishes this cycle
    logic              ack;        // ack relevant to the current wait state
    logic              timeout;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case leaves a signal unassigned and infers a latch.
        pc_rst        = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        csr_we        = 1'b0;
        int_taken     = 1'b0;
        mret_exec     = 1'b0;
        bus.mem_rden1 = 1'b0;
        bus.mem_rden2 = 1'b0;
        bus.mem_we2   = 1'b0;
        state_n       = state;
        complete      = 1'b0;
        ack           = 1'b0;
        timeout       = 1'b0;

        case (state)
            INIT: begin
                // Gated so the pulse covers only the cycle after release,
                // not the whole time reset is held.
                pc_rst  = rst_n;
                state_n = FETCH;
            end

            FETCH: begin
                bus.mem_rden1 = 1'b1;
                ack           = bus.imem_ack;
                if (bus.imem_ack) begin
                    state_n = EXEC;
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout = 1'b1;   // retry the fetch from scratch
                end
            end

            EXEC: begin
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        complete  = 1'b1;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                    OP_LOAD: begin
                        bus.mem_rden2 = 1'b1;
                        state_n       = bus.dmem_ack ? WB : MEM_WAIT;
                    end
                    OP_STORE: begin
                        bus.mem_we2 = 1'b1;
                        if (bus.dmem_ack) begin
                            pc_write = 1'b1;
                            complete = 1'b1;
                        end else begin
                            state_n = MEM_WAIT;
                        end
                    end
                    OP_SYSTEM: begin
                        pc_write = 1'b1;
                        if (func == F_CSRRW) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                            complete  = 1'b1;
                        end else if (func == F_MRET) begin
                            // mret returns straight to FETCH: no interrupt
                            // is taken on the cycle mie is being restored.
                            mret_exec = 1'b1;
                            state_n   = FETCH;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    default: begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                endcase
            end

            MEM_WAIT: begin
                ack = bus.dmem_ack;
                if (is_store) bus.mem_we2   = 1'b1;
                else          bus.mem_rden2 = 1'b1;
                if (bus.dmem_ack) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end else begin
                        state_n = WB;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout = 1'b1;
                    state_n = FETCH;
                end
            end

            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                complete  = 1'b1;
            end

            INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_n   = FETCH;
            end

            default: state_n = INIT;
        endcase

        if (complete) state_n = (intr_q && mie) ? INTR : FETCH;

        bus.bus_err = timeout;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            wait_cnt <= '0;
            intr_q   <= 1'b0;
            is_store <= 1'b0;
            instret  <= '0;
        end else begin
            state  <= state_n;
            intr_q <= intr;

            if (state == EXEC) is_store <= (opcode == OP_STORE);

            if (state_n != state || timeout)
                wait_cnt <= '0;
            else if ((state == FETCH || state == MEM_WAIT) && !ack)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (pc_write && state != INTR)
                instret <= instret + INSTRET_W'(1);
        end
    end
endmodule

// File: tb/tb_cu_fsm.sv
// ----------------------------------------------------------------------------
// tb_cu_fsm -- self-checking bench for cu_fsm.
//
// The reference model is instruction-level: run_instr() knows, for an
// instruction class plus chosen fetch/data wait lengths, which cycles the
// control unit must produce and what each cycle must show. It drives the
// acks for every cycle and publishes the expected output word and instret;
// one compare process checks the DUT against them on every falling edge.
// Directed scenarios pin the model with hand-computed literal counts.
// ----------------------------------------------------------------------------
module tb_cu_fsm;
    localparam int TO = 4;
    localparam int IW = 4;

    // Expected-output word layout, one bit per control output.
    localparam logic [9:0] O_PCRST = 10'h200;
    localparam logic [9:0] O_PCW   = 10'h100;
    localparam logic [9:0] O_RW    = 10'h080;
    localparam logic [9:0] O_R1    = 10'h040;
    localparam logic [9:0] O_R2    = 10'h020;
    localparam logic [9:0] O_W2    = 10'h010;
    localparam logic [9:0] O_CSR   = 10'h008;
    localparam logic [9:0] O_IT    = 10'h004;
    localparam logic [9:0] O_MR    = 10'h002;
    localparam logic [9:0] O_BE    = 10'h001;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    func = '0;
    logic          intr = 1'b0;
    logic          mie = 1'b0;
    logic          pc_rst, pc_write, reg_write, csr_we, int_taken, mret_exec;
    logic [IW-1:0] instret;
    logic [9:0]    dut_out;

    cu_fsm_if bus ();

    cu_fsm #(.TIMEOUT(TO), .INSTRET_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .func      (func),
        .intr      (intr),
        .mie       (mie),
        .bus       (bus),
        .pc_rst    (pc_rst),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .csr_we    (csr_we),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .instret   (instret)
    );

    assign dut_out = {pc_rst, pc_write, reg_write, bus.mem_rden1, bus.mem_rden2,
                      bus.mem_we2, csr_we, int_taken, mret_exec, bus.bus_err};

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // Model state
    int            retired = 0;     // instructions retired since reset
    bit            prev_intr = 1'b0; // intr as sampled at the last edge
    int            intr_force = 0;   // -1: random intr, else forced value
    logic [9:0]    exp_out = '0;
    logic [IW-1:0] exp_instret = '0;
    bit            chk_en = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cnt_pr, cnt_pcw, cnt_rw, cnt_r2, cnt_w2, cnt_it, cnt_be;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs", 32'(dut_out), 32'(exp_out));
            check("instret", 32'(instret), 32'(exp_instret));
            cnt_pr  += int'(pc_rst);
            cnt_pcw += int'(pc_write);
            cnt_rw  += int'(reg_write);
            cnt_r2  += int'(bus.mem_rden2);
            cnt_w2  += int'(bus.mem_we2);
            cnt_it  += int'(int_taken);
            cnt_be  += int'(bus.bus_err);
        end
    end

    task automatic clr_cnt();
        cnt_pr = 0; cnt_pcw = 0; cnt_rw = 0; cnt_r2 = 0;
        cnt_w2 = 0; cnt_it = 0; cnt_be = 0;
    endtask

    // One clock cycle: drive acks/intr, publish expectations, advance.
    task automatic cyc(input logic ia, input logic da, input logic [9:0] e, input bit retire);
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        intr = (intr_force >= 0) ? intr_force[0] : ($urandom_range(0, 3) == 0);
        exp_out     = e;
        exp_instret = IW'(retired);
        @(posedge clk);
        #1;
        prev_intr = intr;
        if (retire) retired = (retired + 1) % (1 << IW);
    endtask

    // Final cycle of an instruction; an interrupt seen at the previous edge
    // with mie set adds one INTR cycle that does not retire.
    task automatic done_cyc(input logic da, input logic [9:0] e);
        bit acc;
        acc = prev_intr && mie;
        cyc(1'b0, da, e, 1'b1);
        if (acc) cyc(1'b0, 1'b0, O_PCW | O_IT, 1'b0);
    endtask

    // df: cycles before imem_ack (each TO+1 empty cycles cost a bus_err retry).
    // dm: cycles after EXEC before dmem_ack (0 = ack in EXEC).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] fn,
                             input int df, input int dm, input logic m);
        int         k;
        int         dleft;
        bit         is_ld;
        logic [9:0] strobe;
        opcode = op;
        func   = fn;
        mie    = m;
        dleft  = df;
        k      = 0;
        while (1) begin
            if (k == dleft) begin
                cyc(1'b1, 1'b0, O_R1, 1'b0);
                break;
            end
            if (k == TO) begin
                cyc(1'b0, 1'b0, O_R1 | O_BE, 1'b0);
                dleft -= TO + 1;
                k = 0;
            end else begin
                cyc(1'b0, 1'b0, O_R1, 1'b0);
                k++;
            end
        end
        case (op)
            OP_R, OP_I, OP_LUI, OP_AUI, OP_JAL, OP_JR: done_cyc(1'b0, O_RW | O_PCW);
            OP_BR: done_cyc(1'b0, O_PCW);
            OP_SYS: begin
                if (fn == 3'd1)      done_cyc(1'b0, O_RW | O_CSR | O_PCW);
                else if (fn == 3'd0) cyc(1'b0, 1'b0, O_MR | O_PCW, 1'b1);
                else                 done_cyc(1'b0, O_PCW);
            end
            OP_LD, OP_ST: begin
                is_ld  = (op == OP_LD);
                strobe = is_ld ? O_R2 : O_W2;
                if (dm == 0) begin
                    if (is_ld) begin
                        cyc(1'b0, 1'b1, O_R2, 1'b0);
                        done_cyc(1'b0, O_RW | O_PCW);
                    end else begin
                        done_cyc(1'b1, O_W2 | O_PCW);
                    end
                end else begin
                    cyc(1'b0, 1'b0, strobe, 1'b0);
                    k = 0;
                    while (1) begin
                        if (k == dm - 1) begin
                            if (is_ld) begin
                                cyc(1'b0, 1'b1, O_R2, 1'b0);
                                done_cyc(1'b0, O_RW | O_PCW);
                            end else begin
                                done_cyc(1'b1, O_W2 | O_PCW);
                            end
                            break;
                        end
                        if (k == TO) begin
                            cyc(1'b0, 1'b0, strobe | O_BE, 1'b0);
                            break;
                        end
                        cyc(1'b0, 1'b0, strobe, 1'b0);
                        k++;
                    end
                end
            end
            default: done_cyc(1'b0, O_PCW);
        endcase
    endtask

    // Called at posedge+1 with rst_n low: release and check the INIT cycle.
    task automatic release_reset();
        retired   = 0;
        prev_intr = 1'b0;
        rst_n     = 1'b1;
        clr_cnt();
        chk_en    = 1'b1;
        cyc(1'b0, 1'b0, O_PCRST, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [6:0] ops [11];
    logic [6:0] rop;
    logic [2:0] rfn;
    int         rsel;

    initial begin
        ops = '{OP_R, OP_I, OP_LUI, OP_AUI, OP_JAL, OP_JR, OP_BR, OP_LD, OP_ST, OP_SYS, 7'b0000000};
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        clr_cnt();

        // Held in reset: everything quiet, including pc_rst.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(dut_out), 32'h0);
        check("reset_instret", 32'(instret), 32'h0);
        release_reset();

        // Three R-type instructions with imem_ack always high.
        intr_force = 0;
        clr_cnt();
        for (int i = 0; i < 3; i++) run_instr(OP_R, 3'd0, 0, 0, 1'b0);
        check("rtype_instret", 32'(instret), 32'd3);
        check("rtype_reg_write", 32'(cnt_rw), 32'd3);
        check("rtype_pc_write", 32'(cnt_pcw), 32'd3);

        // Load with dmem_ack two cycles after EXEC.
        clr_cnt();
        run_instr(OP_LD, 3'd2, 0, 2, 1'b0);
        check("load_rden2_cycles", 32'(cnt_r2), 32'd3);
        check("load_reg_write", 32'(cnt_rw), 32'd1);
        check("load_instret", 32'(instret), 32'd4);

        // Store acked in EXEC, then a store acked after 4 cycles.
        run_instr(OP_ST, 3'd2, 0, 0, 1'b0);
        check("store0_instret", 32'(instret), 32'd5);
        clr_cnt();
        run_instr(OP_ST, 3'd2, 0, 4, 1'b0);
        check("store4_we2_cycles", 32'(cnt_w2), 32'd5);
        check("store4_pc_write", 32'(cnt_pcw), 32'd1);
        check("store4_reg_write", 32'(cnt_rw), 32'd0);
        check("store4_instret", 32'(instret), 32'd6);

        // Interrupt during ADDI, enabled then masked.
        intr_force = 1;
        clr_cnt();
        run_instr(OP_I, 3'd0, 0, 0, 1'b1);
        check("intr_taken", 32'(cnt_it), 32'd1);
        check("intr_pc_write", 32'(cnt_pcw), 32'd2);
        check("intr_instret", 32'(instret), 32'd7);
        clr_cnt();
        run_instr(OP_I, 3'd0, 0, 0, 1'b0);
        check("intr_masked", 32'(cnt_it), 32'd0);
        check("intr_masked_instret", 32'(instret), 32'd8);

        // Fetch timeout: imem_ack held off for TO+1 cycles, then granted.
        intr_force = 0;
        clr_cnt();
        run_instr(OP_I, 3'd0, TO + 1, 0, 1'b0);
        check("timeout_bus_err", 32'(cnt_be), 32'd1);
        check("timeout_pc_write", 32'(cnt_pcw), 32'd1);
        check("timeout_instret", 32'(instret), 32'd9);

        // Randomized instruction mix, wait states, interrupts and timeouts.
        intr_force = -1;
        for (int n = 0; n < 300; n++) begin
            rsel = $urandom_range(0, 11);
            rop  = (rsel == 11) ? 7'($urandom) : ops[rsel];
            rfn  = (rop == OP_SYS) ? 3'($urandom_range(0, 3)) : 3'($urandom);
            run_instr(rop, rfn,
                      ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 11),
                      ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 8),
                      1'($urandom_range(0, 1)));
        end

        // Reset asserted in the middle of a store's MEM_WAIT.
        intr_force = 0;
        mie        = 1'b0;
        opcode     = OP_ST;
        cyc(1'b1, 1'b0, O_R1, 1'b0);
        cyc(1'b0, 1'b0, O_W2, 1'b0);
        cyc(1'b0, 1'b0, O_W2, 1'b0);
        check("midreset_we2_before", 32'(bus.mem_we2), 32'd1);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_we2_after", 32'(bus.mem_we2), 32'd0);
        check("midreset_outputs", 32'(dut_out), 32'h0);
        check("midreset_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        release_reset();
        run_instr(OP_R, 3'd0, 1, 0, 1'b0);
        check("midreset_pc_rst_pulses", 32'(cnt_pr), 32'd1);
        check("midreset_instret_after", 32'(instret), 32'd1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
